// File: rtl/mem_reader_pkg.sv
// Shared definitions for the GPU memory reader: FSM state encoding,
// default FIFO depth and the byte-lane helper used by the packer.
package gpu;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } mem_reader_state_e;

    localparam int MEM_READER_DEFAULT_DEPTH = 8;

    // Byte lane that the idx-th returned byte of a word occupies.
    function automatic logic [1:0] byte_lane(input logic [1:0] idx,
                                             input logic [1:0] last_idx,
                                             input logic       big_endian);
        return big_endian ? (last_idx - idx) : idx;
    endfunction

endpackage

// File: rtl/mem_reader_if.sv
// Avalon-MM read-only bus as seen by the GPU's 8-bit m1 master port.
interface mem_reader_if;

    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [7:0]  readdata;
    logic        readdatavalid;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata,
        output readdatavalid
    );

endinterface

// File: rtl/mem_reader_sync_fifo.sv
// Single-clock FIFO with synchronous reset; push and pop may coincide,
// also when full. The occupancy count feeds the reader's credit check.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    logic full_s;
    logic empty_s;
    logic do_pop_s;
    logic do_push_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign empty_s   = (count_r == {CW{1'b0}});
    assign do_pop_s  = pop && !empty_s;
    assign do_push_s = push && (!full_s || do_pop_s);

    // Storage write port; contents need no reset because the head is gated.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    assign head_data  = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign head_valid = !empty_s;
    assign count      = count_r;

endmodule

// File: rtl/mem_reader.sv
// Avalon-MM byte read initiator that packs returned bytes into words and
// streams them out through a FIFO. Define MEM_READER_BIG_ENDIAN_EN for MSB-first packing.
module mem_reader
    import gpu::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = MEM_READER_DEFAULT_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [31:0]        byte_count,
    output logic               busy,
    output logic               done,
    mem_reader_if.master       m1,
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int OW = $clog2(FIFO_DEPTH * WORD_BYTES) + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int KW = CW + 1;
    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ISSUE  = ISSUE;
    localparam logic [1:0] ST_DRAIN  = DRAIN;
    localparam logic [1:0] ST_FINISH = FINISH;

`ifdef MEM_READER_BIG_ENDIAN_EN
    localparam logic BIG_ENDIAN = 1'b1;
`else
    localparam logic BIG_ENDIAN = 1'b0;
`endif

    logic [1:0]    state_r;
    logic [31:0]   addr_r;
    logic [31:0]   remaining_r;
    logic [31:0]   rx_left_r;
    logic [1:0]    issue_idx_r;
    logic [1:0]    pack_idx_r;
    logic [31:0]   pack_data_r;
    logic [OW-1:0] outstanding_r;
    logic [KW-1:0] reserved_r;
    logic          m1_read_r;
    logic          busy_r;
    logic          done_r;

    logic          accept_s;
    logic          rdv_ok_s;
    logic          push_s;
    logic          pop_s;
    logic          reserve_s;
    logic          final_push_s;
    logic [KW-1:0] committed_nxt_s;
    logic [1:0]    state_nxt_s;
    logic [31:0]   addr_nxt_s;
    logic [31:0]   remaining_nxt_s;
    logic [31:0]   rx_left_nxt_s;
    logic [1:0]    issue_idx_nxt_s;
    logic          read_nxt_s;
    logic [1:0]    lane_s;
    logic [31:0]   word_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_valid_s;
    logic [31:0]   fifo_head_s;

    assign accept_s     = m1_read_r && !m1.waitrequest;
    // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
    assign rdv_ok_s     = m1.readdatavalid && (outstanding_r != {OW{1'b0}});
    assign final_push_s = rdv_ok_s && (rx_left_r == 32'd1);
    assign push_s       = rdv_ok_s && ((pack_idx_r == LAST_IDX) || (rx_left_r == 32'd1));
    assign pop_s        = fifo_valid_s && out_ready;
    assign reserve_s    = accept_s && (issue_idx_r == 2'd0);

    // Merge the incoming byte into the word being assembled.
    always_comb begin
        lane_s = byte_lane(pack_idx_r, LAST_IDX, BIG_ENDIAN);
        word_s = 32'd0;
        for (int b = 0; b < 4; b++) begin
            word_s[8*b +: 8] = (2'(b) == lane_s) ? m1.readdata : pack_data_r[8*b +: 8];
        end
    end

    // Next-state, address/count and credit evaluation.
    always_comb begin
        state_nxt_s     = state_r;
        addr_nxt_s      = accept_s ? (addr_r + 32'd1) : addr_r;
        remaining_nxt_s = accept_s ? (remaining_r - 32'd1) : remaining_r;
        issue_idx_nxt_s = accept_s ? ((issue_idx_r == LAST_IDX) ? 2'd0 : (issue_idx_r + 2'd1))
                                   : issue_idx_r;
        rx_left_nxt_s   = (rdv_ok_s && (rx_left_r != 32'd0)) ? (rx_left_r - 32'd1) : rx_left_r;

        case (state_r)
            ST_IDLE: begin
                if (start && (byte_count != 32'd0)) begin
                    state_nxt_s     = ST_ISSUE;
                    addr_nxt_s      = base_addr;
                    remaining_nxt_s = byte_count;
                    rx_left_nxt_s   = byte_count;
                    issue_idx_nxt_s = 2'd0;
                end else if (start) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (accept_s && (remaining_r == 32'd1)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (final_push_s || ((outstanding_r == {OW{1'b0}}) && (rx_left_r == 32'd0))) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Words held or promised next cycle; a new word may start only below FIFO_DEPTH.
        committed_nxt_s = KW'(fifo_count_s) + reserved_r + KW'(reserve_s) - KW'(pop_s);
        read_nxt_s      = (state_nxt_s == ST_ISSUE) &&
                          ((issue_idx_nxt_s != 2'd0) || (committed_nxt_s < KW'(FIFO_DEPTH)));
    end

    // Control, address and bookkeeping registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            addr_r        <= 32'd0;
            remaining_r   <= 32'd0;
            rx_left_r     <= 32'd0;
            issue_idx_r   <= 2'd0;
            m1_read_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            outstanding_r <= {OW{1'b0}};
            reserved_r    <= {KW{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            addr_r        <= addr_nxt_s;
            remaining_r   <= remaining_nxt_s;
            rx_left_r     <= rx_left_nxt_s;
            issue_idx_r   <= issue_idx_nxt_s;
            m1_read_r     <= read_nxt_s;
            busy_r        <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_DRAIN);
            done_r        <= (state_nxt_s == ST_FINISH);
            outstanding_r <= outstanding_r + OW'(accept_s) - OW'(rdv_ok_s);
            reserved_r    <= reserved_r + KW'(reserve_s) - KW'(push_s);
        end
    end

    // Packer: accumulate bytes, restart from a zeroed word after each push.
    always_ff @(posedge clock) begin
        if (reset) begin
            pack_idx_r  <= 2'd0;
            pack_data_r <= 32'd0;
        end else if (push_s) begin
            pack_idx_r  <= 2'd0;
            pack_data_r <= 32'd0;
        end else if (rdv_ok_s) begin
            pack_idx_r  <= pack_idx_r + 2'd1;
            pack_data_r <= word_s;
        end else begin
            pack_idx_r  <= pack_idx_r;
            pack_data_r <= pack_data_r;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push_s),
        .push_data  (word_s),
        .pop        (pop_s),
        .head_data  (fifo_head_s),
        .head_valid (fifo_valid_s),
        .count      (fifo_count_s)
    );

    assign busy       = busy_r;
    assign done       = done_r;
    assign m1.address = addr_r;
    assign m1.read    = m1_read_r;
    assign out_data   = fifo_head_s;
    assign out_valid  = fifo_valid_s;

endmodule

// File: tb/tb_mem_reader.sv
// Directed self-checking bench for mem_reader with a 2-cycle-latency Avalon
// responder returning addr[7:0]; honours MEM_READER_BIG_ENDIAN_EN expectations.
module tb_mem_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [31:0] byte_count = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        waitreq = 1'b0;
    logic        force_rdv = 1'b0;

    logic        rsp_v1 = 1'b0;
    logic        rsp_v2 = 1'b0;
    logic [7:0]  rsp_d1 = 8'd0;
    logic [7:0]  rsp_d2 = 8'd0;

    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          acc0;
    int          done0;
    logic [31:0] got_q [$];

`ifdef MEM_READER_BIG_ENDIAN_EN
    localparam logic [31:0] W0 = 32'h00010203;
    localparam logic [31:0] W1 = 32'h04050607;
    localparam logic [31:0] P1 = 32'h04050000;
`else
    localparam logic [31:0] W0 = 32'h03020100;
    localparam logic [31:0] W1 = 32'h07060504;
    localparam logic [31:0] P1 = 32'h00000504;
`endif

    mem_reader_if m1 ();

    mem_reader #(
        .WORD_BYTES (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .byte_count (byte_count),
        .busy       (busy),
        .done       (done),
        .m1         (m1),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clock = ~clock;

    assign m1.waitrequest   = waitreq;
    assign m1.readdatavalid = rsp_v2 | force_rdv;
    assign m1.readdata      = force_rdv ? 8'hEE : rsp_d2;

    // Responder pipeline; deliberately not reset so in-flight data turns stale.
    always @(posedge clock) begin
        rsp_v1 <= m1.read && !m1.waitrequest;
        rsp_d1 <= m1.address[7:0];
        rsp_v2 <= rsp_v1;
        rsp_d2 <= rsp_d1;
    end

    always @(posedge clock) begin
        if (m1.read && !m1.waitrequest) acc_cnt <= acc_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (!reset && out_valid && out_ready) got_q.push_back(out_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] addr, input logic [31:0] cnt);
        start      = 1'b1;
        base_addr  = addr;
        byte_count = cnt;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    function automatic logic [31:0] seq_word(input int k);
        logic [7:0] lo;
        lo = 8'(4 * k);
`ifdef MEM_READER_BIG_ENDIAN_EN
        return {lo, lo + 8'd1, lo + 8'd2, lo + 8'd3};
`else
        return {lo + 8'd3, lo + 8'd2, lo + 8'd1, lo};
`endif
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_read",     {31'd0, m1.read},   32'd0);
        chk("rst_address",  m1.address,         32'd0);
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_done",     {31'd0, done},      32'd0);
        chk("rst_out_valid",{31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data,           32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Basic 8-byte transfer
        out_ready = 1'b1;
        got_q.delete();
        acc0 = acc_cnt; done0 = done_cnt;
        do_start(32'h1000, 32'd8);
        chk("t1_first_read", {31'd0, m1.read}, 32'd1);
        chk("t1_first_addr", m1.address,       32'h1000);
        chk("t1_busy",       {31'd0, busy},    32'd1);
        wait_done(60);
        chk("t1_done_busy",  {31'd0, busy},    32'd0);
        repeat (3) @(negedge clock);
        chk("t1_words",  32'(got_q.size()),       32'd2);
        chk("t1_word0",  got_q[0],                W0);
        chk("t1_word1",  got_q[1],                W1);
        chk("t1_accepts",32'(acc_cnt - acc0),     32'd8);
        chk("t1_dones",  32'(done_cnt - done0),   32'd1);

        // Partial final word
        got_q.delete();
        do_start(32'h2000, 32'd6);
        wait_done(60);
        repeat (3) @(negedge clock);
        chk("t2_words", 32'(got_q.size()), 32'd2);
        chk("t2_word0", got_q[0],          W0);
        chk("t2_word1", got_q[1],          P1);

        // Three-cycle waitrequest stall on the second read
        got_q.delete();
        acc0 = acc_cnt;
        do_start(32'h1000, 32'd8);
        @(negedge clock);
        waitreq = 1'b1;
        chk("t3_hold0", m1.address, 32'h1001);
        @(negedge clock);
        chk("t3_hold1", m1.address, 32'h1001);
        chk("t3_read_held", {31'd0, m1.read}, 32'd1);
        @(negedge clock);
        chk("t3_hold2", m1.address, 32'h1001);
        @(negedge clock);
        waitreq = 1'b0;
        chk("t3_hold3", m1.address, 32'h1001);
        wait_done(80);
        repeat (3) @(negedge clock);
        chk("t3_words",   32'(got_q.size()),   32'd2);
        chk("t3_word0",   got_q[0],            W0);
        chk("t3_word1",   got_q[1],            W1);
        chk("t3_accepts", 32'(acc_cnt - acc0), 32'd8);

        // Back-pressure: FIFO fills, issue stops after 32 bytes
        got_q.delete();
        out_ready = 1'b0;
        acc0 = acc_cnt;
        do_start(32'h3000, 32'd64);
        repeat (80) @(negedge clock);
        chk("t4_stop_accepts", 32'(acc_cnt - acc0),  32'd32);
        chk("t4_read_low",     {31'd0, m1.read},     32'd0);
        chk("t4_out_valid",    {31'd0, out_valid},   32'd1);
        chk("t4_busy",         {31'd0, busy},        32'd1);
        chk("t4_head",         out_data,             seq_word(0));
        out_ready = 1'b1;
        wait_done(400);
        repeat (3) @(negedge clock);
        chk("t4_words",    32'(got_q.size()),   32'd16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t4_word%0d", k), got_q[k], seq_word(k));
        end
        chk("t4_accepts",  32'(acc_cnt - acc0), 32'd64);

        // Zero-length request
        got_q.delete();
        acc0 = acc_cnt; done0 = done_cnt;
        do_start(32'h6000, 32'd0);
        chk("t5_done",      {31'd0, done},      32'd1);
        chk("t5_read",      {31'd0, m1.read},   32'd0);
        @(negedge clock);
        chk("t5_done_off",  {31'd0, done},      32'd0);
        repeat (3) @(negedge clock);
        chk("t5_accepts",   32'(acc_cnt - acc0),   32'd0);
        chk("t5_out_valid", {31'd0, out_valid},    32'd0);
        chk("t5_dones",     32'(done_cnt - done0), 32'd1);

        // Reset with reads outstanding, then stale responses
        got_q.delete();
        done0 = done_cnt;
        do_start(32'h4000, 32'd16);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_read",      {31'd0, m1.read},   32'd0);
        chk("t6_address",   m1.address,         32'd0);
        chk("t6_busy",      {31'd0, busy},      32'd0);
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_out_data",  out_data,           32'd0);
        @(negedge clock);
        reset = 1'b0;
        force_rdv = 1'b1;
        repeat (2) @(negedge clock);
        force_rdv = 1'b0;
        repeat (3) @(negedge clock);
        chk("t6_idle_busy",  {31'd0, busy},       32'd0);
        chk("t6_no_valid",   {31'd0, out_valid},  32'd0);
        chk("t6_no_words",   32'(got_q.size()),   32'd0);
        chk("t6_no_done",    32'(done_cnt - done0), 32'd0);
        do_start(32'h5000, 32'd4);
        wait_done(60);
        repeat (3) @(negedge clock);
        chk("t6_after_words", 32'(got_q.size()), 32'd1);
        chk("t6_after_word0", got_q[0],          W0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_reader.md
# mem_reader

Avalon-MM read initiator for the GPU's 8-bit `m1` master port. On a start pulse it issues pipelined single-byte reads from `base_addr` for `byte_count` bytes, honouring `waitrequest` and `readdatavalid`. It packs the returned bytes into words and presents them on a valid/ready stream through an internal FIFO. `gpu_controller` instantiates it to fetch voxel and palette buffers from SDRAM.

## Interface
Parameters:
- `WORD_BYTES`, 4: bytes packed per output word; legal 1..4.
- `FIFO_DEPTH`, 8: output FIFO depth in words; power of 2, ≥2.

Ports:
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; ignored while `busy`.
- `base_addr`  in  32  byte address of the first read.
- `byte_count`  in  32  number of bytes to read.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `m1_address`  out  32  Avalon read address.
- `m1_read`  out  1  Avalon read request.
- `m1_waitrequest`  in  1  Avalon stall.
- `m1_readdata`  in  8  Avalon read data.
- `m1_readdatavalid`  in  1  Avalon response strobe.
- `out_data`  out  32  packed word; bits above `8*WORD_BYTES` are 0.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head.

## Operation
- States (`mem_reader_state_e`): IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - `start` with `byte_count`>0: latch address and count, go to ISSUE, set `busy`.
  - `start` with `byte_count`==0: go to FINISH and issue no reads.
- ISSUE:
  - Drive `m1_read`=1 with `m1_address` = current address, held stable while `m1_waitrequest`=1.
  - A read is accepted in any cycle with `m1_read && !m1_waitrequest`. On acceptance: address +1, remaining −1.
  - When the last byte is accepted, go to DRAIN.
- Flow control:
  - A word slot is reserved when the first byte of that word is issued.
  - No new word may be started while (FIFO occupancy + reserved-not-yet-pushed words) == `FIFO_DEPTH`. While blocked, `m1_read`=0.
  - Bytes within an already-reserved word are never blocked.
- Packing: little-endian. The first returned byte of a word goes to bits [7:0]. A word is pushed to the FIFO once `WORD_BYTES` bytes have arrived, or when the final byte arrives (partial word, zero-padded).
- DRAIN: wait until the outstanding-response count is 0 and the final word has been pushed, then go to FINISH.
- FINISH: `done`=1 for one cycle, `busy`=0, return to IDLE. Words still in the FIFO remain readable. A new `start` may arrive while the FIFO is non-empty.
- A `readdatavalid` with zero outstanding reads (including responses arriving after a reset) is dropped.
- Address arithmetic wraps modulo 2^32. Outstanding counter width is `$clog2(FIFO_DEPTH*WORD_BYTES)+1`.

## Timing
- Reset values: `m1_read`=0, `m1_address`=0, `busy`=0, `done`=0, `out_valid`=0, `out_data`=0. FIFO is emptied and the outstanding count is 0.
- Reset mid-transfer aborts the transfer and returns to IDLE without a `done` pulse.
- Start to first `m1_read`: 1 cycle, i.e. registered and asserted in the cycle after `start`.
- Issue rate: 1 byte/cycle with no stall.
- `readdatavalid` to FIFO push: same-cycle registration. `out_valid` rises the cycle after the push, so first-word latency is 1 cycle after the completing byte.
- FIFO supports push and pop in the same cycle, including when full.
- `done` is asserted the cycle after the last push. With `byte_count`==0, `done` is asserted 1 cycle after `start`.

## Configuration
- `MEM_READER_BIG_ENDIAN_EN`:
  - Defined: the first byte of each word lands in the most significant used byte, bits [8*WORD_BYTES-1 : 8*WORD_BYTES-8]. Partial words are zero-padded in the low bytes.
  - Undefined: little-endian packing as described under Operation.

## Structure
- Package `gpu`: `mem_reader_state_e` enum; `MEM_READER_DEFAULT_DEPTH` constant.
- Sub-module `sync_fifo`: parameterised width/depth, synchronous reset, `count` output used for the credit check.
- FSM, issue logic, packer and outstanding counter live in `mem_reader`.

## Test plan
- `base_addr`=0x1000, `byte_count`=8, zero-wait responder with 2-cycle read latency returning addr[7:0] -> `out_data` 0x03020100 then 0x07060504; exactly 8 `m1_read` acceptances; `done` pulses once.
- `byte_count`=6, `WORD_BYTES`=4 -> words 0x03020100 and 0x00000504. With `MEM_READER_BIG_ENDIAN_EN`: 0x00010203 and 0x04050000.
- `m1_waitrequest` high for 3 cycles on the second read -> `m1_address` held at 0x1001 through the stall; no duplicate or missing byte.
- `out_ready`=0, `byte_count`=64, `FIFO_DEPTH`=8 -> `m1_read` stops after 32 bytes; FIFO holds 8 words. Raising `out_ready` resumes issue and all 16 words arrive in order.
- `byte_count`=0 -> `done` one cycle after `start`; no `m1_read`; `out_valid` stays 0.
- `reset` asserted with 3 reads outstanding, then stale `readdatavalid` pulses -> all outputs at reset values; stale bytes dropped; no `done`.
